// File: rtl/dpram_port_arbiter.sv
// rtl/dpram_port_arbiter.sv - round-robin arbiter sharing one dual-port RAM port between two requesters
module dpram_port_arbiter #(
    parameter int AW = 15
) (
    input  logic          clk,
    input  logic          rstf,

    input  logic          t_r0_valid,
    output logic          t_r0_ready,
    input  logic          t_r0_we,
    input  logic [AW-1:0] t_r0_addr,
    input  logic [31:0]   t_r0_data,
    input  logic [3:0]    t_r0_mask,

    input  logic          t_r1_valid,
    output logic          t_r1_ready,
    input  logic          t_r1_we,
    input  logic [AW-1:0] t_r1_addr,
    input  logic [31:0]   t_r1_data,
    input  logic [3:0]    t_r1_mask,

    output logic          i_r0_valid,
    input  logic          i_r0_ready,
    output logic [31:0]   i_r0_data,

    output logic          i_r1_valid,
    input  logic          i_r1_ready,
    output logic [31:0]   i_r1_data,

    output logic          i_m_valid,
    output logic          i_m_we,
    output logic [AW-1:0] i_m_addr,
    output logic [31:0]   i_m_data,
    output logic [3:0]    i_m_mask,
    input  logic          t_m_ready,
    input  logic          t_m_valid,
    input  logic [31:0]   t_m_data,

    output logic          err
);

    logic       rr;
    logic       pend_v;
    logic       pend_id;
    logic       buf0_v;
    logic       buf1_v;

    logic [1:0] buf_v;
    logic [1:0] req_valid;
    logic [1:0] req_we;
    logic [1:0] pop;
    logic [1:0] slot_free;
    logic [1:0] rd_busy;
    logic [1:0] elig;
    logic [1:0] load;
    logic       any_elig;
    logic       gnt_id;
    logic       accept;
    logic       accept_rd;

    assign buf_v = {buf1_v, buf0_v};

    // A read may only issue if its response has a guaranteed landing slot:
    // the buffer is free (or draining now) and no earlier read is still in flight.
    always_comb begin
        req_valid = {t_r1_valid, t_r0_valid};
        req_we    = {t_r1_we, t_r0_we};
        pop       = buf_v & {i_r1_ready, i_r0_ready};
        slot_free = ~buf_v | pop;
        rd_busy   = {pend_v & pend_id, pend_v & ~pend_id};
        elig      = req_valid & (req_we | (slot_free & ~rd_busy));
        any_elig  = |elig;
        gnt_id    = elig[rr] ? rr : ~rr;
        accept    = any_elig & t_m_ready;
        accept_rd = accept & ~req_we[gnt_id];
        load      = {2{t_m_valid & pend_v}} & {pend_id, ~pend_id};
    end

    assign t_r0_ready = accept & ~gnt_id;
    assign t_r1_ready = accept & gnt_id;

    assign i_m_valid = any_elig;
    assign i_m_we    = gnt_id ? t_r1_we   : t_r0_we;
    assign i_m_addr  = gnt_id ? t_r1_addr : t_r0_addr;
    assign i_m_data  = gnt_id ? t_r1_data : t_r0_data;
    assign i_m_mask  = gnt_id ? t_r1_mask : t_r0_mask;

    assign i_r0_valid = buf0_v;
    assign i_r1_valid = buf1_v;

    always_ff @(posedge clk or negedge rstf) begin
        if (!rstf) begin
            rr      <= 1'b0;
            pend_v  <= 1'b0;
            pend_id <= 1'b0;
            err     <= 1'b0;
        end else begin
            if (accept) begin
                rr <= ~gnt_id;
            end
            pend_v <= accept_rd;
            if (accept_rd) begin
                pend_id <= gnt_id;
            end
            // Response without a pending read, or a pending read without a response.
            err <= err | (t_m_valid ^ pend_v);
        end
    end

    always_ff @(posedge clk or negedge rstf) begin
        if (!rstf) begin
            buf0_v    <= 1'b0;
            i_r0_data <= 32'd0;
        end else if (load[0]) begin
            buf0_v    <= 1'b1;
            i_r0_data <= t_m_data;
        end else if (pop[0]) begin
            buf0_v    <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rstf) begin
        if (!rstf) begin
            buf1_v    <= 1'b0;
            i_r1_data <= 32'd0;
        end else if (load[1]) begin
            buf1_v    <= 1'b1;
            i_r1_data <= t_m_data;
        end else if (pop[1]) begin
            buf1_v    <= 1'b0;
        end
    end

endmodule
